// File: rtl/idex_hazard_ctrl.sv
// Load-use hazard / flush sequencer driving PC, IF/ID and ID/EX register controls.
// Optional HAZARD_STATS_EN adds saturating stall and flush cycle counters.
module idex_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] id_rn,
  input  logic [3:0] id_rm,
  input  logic [3:0] id_rd,
  input  logic       id_use_rn,
  input  logic       id_use_rm,
  input  logic       id_use_rd,
  input  logic       ex_load,
  input  logic       ex_rf,
  input  logic [3:0] ex_rd,
  input  logic       br_taken,
  input  logic       flush_i,
  output logic       pc_ld,
  output logic       ifid_ld,
  output logic       ifid_clr,
  output logic       idex_clr,
  output logic       stall_o,
  output logic       state_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
`endif
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu;

  assign lu = ex_load & ex_rf & ((id_use_rn & (id_rn == ex_rd)) |
                                 (id_use_rm & (id_rm == ex_rd)) |
                                 (id_use_rd & (id_rd == ex_rd)));

  assign state_o = state_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Counter holds the bubbles still owed after the current one.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      state_d     = RUN;
      stall_cnt_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (lu && (LOAD_STALL_CYCLES > 1)) begin
            state_d     = STALL;
            stall_cnt_d = CNT_W'(LOAD_STALL_CYCLES - 1);
          end
        end
        STALL: begin
          stall_cnt_d = stall_cnt_q - CNT_W'(1);
          if (stall_cnt_q == CNT_W'(1)) state_d = RUN;
        end
        default: begin
          state_d     = RUN;
          stall_cnt_d = '0;
        end
      endcase
    end
  end

  // Reset is decoded combinationally so the controls are safe while RST_N is low.
  always_comb begin
    pc_ld    = 1'b1;
    ifid_ld  = 1'b1;
    ifid_clr = 1'b0;
    idex_clr = 1'b0;
    stall_o  = 1'b0;
    if (!RST_N) begin
      pc_ld    = 1'b0;
      ifid_ld  = 1'b0;
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else if (flush_i) begin
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else if ((state_q == STALL) || lu) begin
      pc_ld    = 1'b0;
      ifid_ld  = 1'b0;
      idex_clr = 1'b1;
      stall_o  = 1'b1;
    end else if (br_taken) begin
      ifid_clr = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_stat_q, stall_stat_d;
  logic [15:0] flush_stat_q, flush_stat_d;

  always_comb begin
    stall_stat_d = stall_stat_q;
    flush_stat_d = flush_stat_q;
    if (stall_o && (stall_stat_q != 16'hFFFF)) stall_stat_d = stall_stat_q + 16'd1;
    if (ifid_clr && RST_N && (flush_stat_q != 16'hFFFF)) flush_stat_d = flush_stat_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_stat_q <= '0;
      flush_stat_q <= '0;
    end else begin
      stall_stat_q <= stall_stat_d;
      flush_stat_q <= flush_stat_d;
    end
  end

  assign stall_cnt_o = stall_stat_q;
  assign flush_cnt_o = flush_stat_q;
`endif

endmodule
